// File: rtl/posi_tra_arb_if.sv
// Requester/engine signal bundle for the transform-engine arbiter.
// slave = arbiter view, master = requesters + engine view.
interface posi_tra_arb_if #(
    parameter int POS_WD  = 8,
    parameter int SIZE_WD = 2
);
    logic               req0_start_i;
    logic               req0_mode_i;
    logic [SIZE_WD-1:0] req0_size_i;
    logic [POS_WD-1:0]  req0_pos_i;
    logic               req0_done_o;

    logic               req1_start_i;
    logic               req1_mode_i;
    logic [SIZE_WD-1:0] req1_size_i;
    logic [POS_WD-1:0]  req1_pos_i;
    logic               req1_done_o;

    logic               tra_start_o;
    logic               tra_mode_o;
    logic [SIZE_WD-1:0] tra_size_o;
    logic [POS_WD-1:0]  tra_pos_o;
    logic               tra_done_i;
    logic               tra_busy_o;

    logic [1:0]         grant_o;
    logic               err_ovf_o;
    logic               err_tmo_o;

    modport slave (
        input  req0_start_i, req0_mode_i, req0_size_i, req0_pos_i,
        input  req1_start_i, req1_mode_i, req1_size_i, req1_pos_i,
        input  tra_done_i,
        output req0_done_o, req1_done_o,
        output tra_start_o, tra_mode_o, tra_size_o, tra_pos_o, tra_busy_o,
        output grant_o, err_ovf_o, err_tmo_o
    );

    modport master (
        output req0_start_i, req0_mode_i, req0_size_i, req0_pos_i,
        output req1_start_i, req1_mode_i, req1_size_i, req1_pos_i,
        output tra_done_i,
        input  req0_done_o, req1_done_o,
        input  tra_start_o, tra_mode_o, tra_size_o, tra_pos_o, tra_busy_o,
        input  grant_o, err_ovf_o, err_tmo_o
    );
endinterface

// File: rtl/posi_tra_arb.sv
// Round-robin arbiter sharing one transform engine between two requesters; start->tra_start 2 cycles.
// No backpressure: a start while that requester is still pending is dropped and flagged on err_ovf_o.
module posi_tra_arb #(
    parameter int POS_WD  = 8,
    parameter int SIZE_WD = 2,
    parameter int TMO_WD  = 10,
    parameter int TMO_MAX = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    posi_tra_arb_if.slave     bus
);
    localparam int CFG_WD = 1 + SIZE_WD + POS_WD;
    localparam logic [TMO_WD-1:0] TMO_LIM = (TMO_MAX == 0) ? '0 : TMO_WD'(TMO_MAX - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_pend;
    logic [CFG_WD-1:0]  r_hold0;
    logic [CFG_WD-1:0]  r_hold1;
    logic               r_owner;
    logic               r_last_owner;
    logic [TMO_WD-1:0]  r_cnt;

    logic               r_tra_start;
    logic               r_busy;
    logic [1:0]         r_grant;
    logic [1:0]         r_done;
    logic               r_ovf;
    logic               r_tmo;
    logic [CFG_WD-1:0]  r_cfg;

    logic [1:0]         w_start;
    logic [1:0]         w_take;
    logic [1:0]         w_clr;
    logic [CFG_WD-1:0]  w_cfg0;
    logic [CFG_WD-1:0]  w_cfg1;
    logic               w_go;
    logic               w_pick;
    logic               w_tmo_hit;
    logic               w_exit;

    logic               w_tra_start_nxt;
    logic               w_busy_nxt;
    logic [1:0]         w_grant_nxt;
    logic [1:0]         w_done_nxt;
    logic               w_ovf_nxt;
    logic               w_tmo_nxt;
    logic [CFG_WD-1:0]  w_cfg_nxt;

    assign w_start = {bus.req1_start_i, bus.req0_start_i};
    assign w_take  = w_start & ~r_pend;
    assign w_cfg0  = {bus.req0_mode_i, bus.req0_size_i, bus.req0_pos_i};
    assign w_cfg1  = {bus.req1_mode_i, bus.req1_size_i, bus.req1_pos_i};

    // On a tie the requester that did not own the engine last goes next.
    assign w_go      = (r_state == S_IDLE) && (r_pend != 2'b00);
    assign w_pick    = (&r_pend) ? ~r_last_owner : r_pend[1];
    assign w_tmo_hit = (TMO_MAX != 0) && (r_cnt == TMO_LIM);
    assign w_exit    = (r_state == S_RUN) && (bus.tra_done_i || w_tmo_hit);
    assign w_clr     = w_exit ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_pend != 2'b00) w_state_nxt = S_RUN;
            S_RUN:  if (w_exit)          w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tra_start_nxt = w_go;
        w_busy_nxt      = (w_state_nxt == S_RUN);
        w_done_nxt      = w_clr;
        w_ovf_nxt       = |(w_start & r_pend);
        w_tmo_nxt       = w_exit && !bus.tra_done_i;
        w_grant_nxt     = r_grant;
        w_cfg_nxt       = r_cfg;
        if (w_go) begin
            w_grant_nxt = w_pick ? 2'b10 : 2'b01;
            w_cfg_nxt   = w_pick ? r_hold1 : r_hold0;
        end else if (w_exit) begin
            w_grant_nxt = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend       <= 2'b00;
            r_hold0      <= '0;
            r_hold1      <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= '0;
        end else begin
            // The owner's pend bit stays set until release, so its hold regs cannot change mid-job.
            r_pend <= (r_pend | w_take) & ~w_clr;
            if (w_take[0]) r_hold0 <= w_cfg0;
            if (w_take[1]) r_hold1 <= w_cfg1;
            if (w_go) begin
                r_owner <= w_pick;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + TMO_WD'(1);
            end
            if (w_exit) r_last_owner <= r_owner;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tra_start <= 1'b0;
            r_busy      <= 1'b0;
            r_grant     <= 2'b00;
            r_done      <= 2'b00;
            r_ovf       <= 1'b0;
            r_tmo       <= 1'b0;
            r_cfg       <= '0;
        end else begin
            r_tra_start <= w_tra_start_nxt;
            r_busy      <= w_busy_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_ovf       <= w_ovf_nxt;
            r_tmo       <= w_tmo_nxt;
            r_cfg       <= w_cfg_nxt;
        end
    end

    assign bus.tra_start_o = r_tra_start;
    assign bus.tra_busy_o  = r_busy;
    assign bus.grant_o     = r_grant;
    assign bus.req0_done_o = r_done[0];
    assign bus.req1_done_o = r_done[1];
    assign bus.err_ovf_o   = r_ovf;
    assign bus.err_tmo_o   = r_tmo;
    assign {bus.tra_mode_o, bus.tra_size_o, bus.tra_pos_o} = r_cfg;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(r_grant));
    a_cfg_stable:   assert property (@(posedge clk) disable iff (!rstn)
                                     (r_busy && !r_tra_start) |-> $stable(r_cfg));
    a_busy_grant:   assert property (@(posedge clk) disable iff (!rstn) r_busy == (r_grant != 2'b00));
endmodule

// File: tb/tb_posi_tra_arb.sv
// Randomized and directed bench for posi_tra_arb against a job-level reference model.
module tb_posi_tra_arb;
    localparam int POS_WD  = 8;
    localparam int SIZE_WD = 2;
    localparam int TMO_WD  = 10;
    localparam int TMO_MAX = 8;
    localparam int CW      = 1 + SIZE_WD + POS_WD;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    posi_tra_arb_if #(.POS_WD(POS_WD), .SIZE_WD(SIZE_WD)) bus();

    posi_tra_arb #(
        .POS_WD (POS_WD),
        .SIZE_WD(SIZE_WD),
        .TMO_WD (TMO_WD),
        .TMO_MAX(TMO_MAX)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which requesters have a job waiting, their configs, who owns the engine.
    bit            m_pend [2];
    logic [CW-1:0] m_cfg  [2];
    int            m_owner;
    int            m_age;
    int            m_last;
    logic          e_start, e_busy, e_ovf, e_tmo;
    logic [1:0]    e_grant, e_done;
    logic [CW-1:0] e_cfg;
    int            eng_due;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk(input bit m, input logic [SIZE_WD-1:0] s, input logic [POS_WD-1:0] p);
        return {m, s, p};
    endfunction

    task automatic model_reset();
        m_pend[0] = 0; m_pend[1] = 0;
        m_cfg[0] = '0; m_cfg[1] = '0;
        m_owner = -1; m_age = 0; m_last = 1;
        e_start = 0; e_busy = 0; e_ovf = 0; e_tmo = 0;
        e_grant = 2'b00; e_done = 2'b00; e_cfg = '0;
    endtask

    task automatic model_step(input bit s0, input bit s1, input logic [CW-1:0] c0,
                              input logic [CW-1:0] c1, input bit dn);
        bit np [2];
        bit fin;
        int ch;
        e_start = 0; e_done = 2'b00; e_tmo = 0;
        e_ovf = (s0 && m_pend[0]) || (s1 && m_pend[1]);
        np[0] = m_pend[0]; np[1] = m_pend[1];
        fin = (m_owner >= 0) && (dn || (TMO_MAX != 0 && m_age == TMO_MAX - 1));
        if (m_owner < 0 && (m_pend[0] || m_pend[1])) begin
            if (m_pend[0] && m_pend[1]) ch = 1 - m_last;
            else ch = m_pend[0] ? 0 : 1;
            m_owner = ch; m_age = 0;
            e_start = 1; e_busy = 1;
            e_grant = (ch == 1) ? 2'b10 : 2'b01;
            e_cfg = m_cfg[ch];
        end else if (fin) begin
            e_done = (m_owner == 1) ? 2'b10 : 2'b01;
            e_tmo = !dn;
            np[m_owner] = 0;
            m_last = m_owner; m_owner = -1;
            e_grant = 2'b00; e_busy = 0;
        end else if (m_owner >= 0) begin
            m_age++;
        end
        if (s0 && !m_pend[0]) begin np[0] = 1; m_cfg[0] = c0; end
        if (s1 && !m_pend[1]) begin np[1] = 1; m_cfg[1] = c1; end
        m_pend[0] = np[0]; m_pend[1] = np[1];
    endtask

    task automatic compare_all();
        chk("tra_start", bus.tra_start_o, e_start);
        chk("tra_busy",  bus.tra_busy_o,  e_busy);
        chk("grant",     bus.grant_o,     e_grant);
        chk("done",      {bus.req1_done_o, bus.req0_done_o}, e_done);
        chk("err_ovf",   bus.err_ovf_o,   e_ovf);
        chk("err_tmo",   bus.err_tmo_o,   e_tmo);
        chk("tra_cfg",   {bus.tra_mode_o, bus.tra_size_o, bus.tra_pos_o}, e_cfg);
    endtask

    // Drive one cycle of inputs, then check the registered outputs just after the edge.
    task automatic drive(input bit s0, input bit s1, input logic [CW-1:0] c0,
                         input logic [CW-1:0] c1, input bit dn);
        {bus.req0_mode_i, bus.req0_size_i, bus.req0_pos_i} = c0;
        {bus.req1_mode_i, bus.req1_size_i, bus.req1_pos_i} = c1;
        bus.req0_start_i = s0;
        bus.req1_start_i = s1;
        bus.tra_done_i   = dn;
        model_step(s0, s1, c0, c1, dn);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, '0, '0, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.req0_start_i = 0; bus.req1_start_i = 0; bus.tra_done_i = 0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        idle(1);
    endtask

    bit r_s0, r_s1, r_dn;
    logic [CW-1:0] r_c0, r_c1;

    initial begin
        eng_due = -1;
        do_reset();

        // Single job: start @0, engine start @2, engine done @9 (also the timeout cycle).
        drive(1, 0, mk(0, 2, 8'h10), '0, 0);
        idle(1);
        chk("d1_start", bus.tra_start_o, 1);
        chk("d1_grant", bus.grant_o, 2'b01);
        chk("d1_cfg", {bus.tra_mode_o, bus.tra_size_o, bus.tra_pos_o}, {1'b0, 2'd2, 8'h10});
        idle(7);
        drive(0, 0, '0, '0, 1);
        chk("d1_done", bus.req0_done_o, 1);
        chk("d1_busy", bus.tra_busy_o, 0);
        chk("d1_tmo", bus.err_tmo_o, 0);

        // Tie after reset: req0, then req1, then req0 again on the next tie.
        do_reset();
        drive(1, 1, mk(1, 1, 8'h21), mk(0, 3, 8'h42), 0);
        idle(1);
        chk("tie1_grant", bus.grant_o, 2'b01);
        drive(0, 0, '0, '0, 1);
        chk("tie1_done", bus.req0_done_o, 1);
        idle(1);
        chk("tie2_grant", bus.grant_o, 2'b10);
        chk("tie2_cfg", {bus.tra_mode_o, bus.tra_size_o, bus.tra_pos_o}, {1'b0, 2'd3, 8'h42});
        drive(0, 0, '0, '0, 1);
        chk("tie2_done", bus.req1_done_o, 1);
        drive(1, 1, mk(1, 0, 8'h05), mk(1, 2, 8'h06), 0);
        idle(1);
        chk("tie3_grant", bus.grant_o, 2'b01);
        drive(0, 0, '0, '0, 1);
        idle(2);
        drive(0, 0, '0, '0, 1);
        idle(1);

        // Double start while pending, then a job that only ends by timeout.
        drive(1, 0, mk(1, 1, 8'hA5), '0, 0);
        drive(1, 0, mk(0, 3, 8'h5A), '0, 0);
        chk("ovf_pulse", bus.err_ovf_o, 1);
        chk("ovf_cfg", {bus.tra_mode_o, bus.tra_size_o, bus.tra_pos_o}, {1'b1, 2'd1, 8'hA5});
        idle(1);
        chk("ovf_clear", bus.err_ovf_o, 0);
        idle(7);
        chk("tmo_done", bus.req0_done_o, 1);
        chk("tmo_err", bus.err_tmo_o, 1);
        idle(1);
        chk("tmo_idle", bus.tra_busy_o, 0);

        // Engine done while idle is ignored.
        drive(0, 0, '0, '0, 1);
        chk("idle_done", {bus.req1_done_o, bus.req0_done_o}, 2'b00);
        chk("idle_busy", bus.tra_busy_o, 0);

        // Reset in the middle of a job.
        drive(0, 1, '0, mk(1, 3, 8'hEE), 0);
        idle(2);
        chk("pre_rst_busy", bus.tra_busy_o, 1);
        #1;
        do_reset();
        idle(10);

        // Random traffic; the engine answers 0..10 cycles after start, so some jobs time out.
        for (int i = 0; i < 3000; i++) begin
            r_s0 = ($urandom_range(0, 3) == 0);
            r_s1 = ($urandom_range(0, 3) == 0);
            r_c0 = CW'($urandom);
            r_c1 = CW'($urandom);
            r_dn = (eng_due == 0) || ($urandom_range(0, 49) == 0);
            drive(r_s0, r_s1, r_c0, r_c1, r_dn);
            if (eng_due >= 0) eng_due--;
            if (e_start) eng_due = $urandom_range(0, 10);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
